// File: rtl/etc_calc_arbiter_if.sv
// Lane/datapath bundle for the ETC speed-calculation arbiter.
// master = arbiter side, slave = lane controllers plus shared datapath.
interface etc_calc_arbiter_if #(
  parameter int NUM_LANES   = 4,
  parameter int WIDTH_TIK   = 16,
  parameter int WIDTH_SPEED = 14
);
  localparam int GID_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic [NUM_LANES-1:0]           req;
  logic [NUM_LANES*WIDTH_TIK-1:0] tik_in;
  logic                           dp_start;
  logic [WIDTH_TIK-1:0]           dp_tik;
  logic                           dp_done;
  logic [WIDTH_SPEED-1:0]         dp_speed;
  logic [NUM_LANES-1:0]           ack;
  logic [WIDTH_SPEED-1:0]         speed_out;
  logic                           err;
  logic                           busy;
  logic [GID_W-1:0]               grant_id;

  modport master (
    input  req, tik_in, dp_done, dp_speed,
    output dp_start, dp_tik, ack, speed_out, err, busy, grant_id
  );

  modport slave (
    output req, tik_in, dp_done, dp_speed,
    input  dp_start, dp_tik, ack, speed_out, err, busy, grant_id
  );
endinterface

// File: rtl/etc_calc_arbiter.sv
// Round-robin arbiter sharing one speed-calculation datapath between lane
// controllers; aborts with err when the datapath does not answer in time.
module etc_calc_arbiter #(
  parameter int NUM_LANES   = 4,
  parameter int WIDTH_TIK   = 16,
  parameter int WIDTH_SPEED = 14,
  parameter int TIMEOUT     = 1023
) (
  input  logic                 clk,
  input  logic                 reset,
  etc_calc_arbiter_if.master   bus
);
  localparam int GID_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t                 state_q, state_d;
  logic [GID_W-1:0]       grant_q, grant_d;
  logic [GID_W-1:0]       last_q, last_d;
  logic [WIDTH_TIK-1:0]   tik_q, tik_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [WIDTH_SPEED-1:0] speed_q, speed_d;
  logic                   err_q, err_d;
  logic [NUM_LANES-1:0]   ack_q, ack_d;
  logic                   start_q, start_d;
  logic                   busy_q, busy_d;

  logic [WIDTH_TIK-1:0]   tik_arr_s [NUM_LANES];
  logic                   found_s;
  logic [GID_W-1:0]       sel_s;
  logic [GID_W-1:0]       idx_s;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_tik
    assign tik_arr_s[g] = bus.tik_in[g*WIDTH_TIK +: WIDTH_TIK];
  end

  // Next-state, round-robin pick and registered-output precompute
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    tik_d   = tik_q;
    timer_d = timer_q;
    speed_d = speed_q;
    err_d   = 1'b0;
    ack_d   = '0;
    start_d = 1'b0;
    found_s = 1'b0;
    sel_s   = '0;
    idx_s   = '0;

    // Search upward from the lane after the last served one, wrapping.
    for (int k = 1; k <= NUM_LANES; k++) begin
      idx_s = GID_W'((int'(last_q) + k) % NUM_LANES);
      if (!found_s && bus.req[idx_s]) begin
        found_s = 1'b1;
        sel_s   = idx_s;
      end else begin
        found_s = found_s;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          grant_d = sel_s;
          tik_d   = tik_arr_s[sel_s];
          start_d = 1'b1;
          state_d = S_LAUNCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LAUNCH: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done in the timeout cycle still counts as a good result.
        if (bus.dp_done) begin
          speed_d         = bus.dp_speed;
          err_d           = 1'b0;
          ack_d[grant_q]  = 1'b1;
          state_d         = S_RESP;
        end else if (timer_q == TMR_W'(TIMEOUT)) begin
          speed_d         = '0;
          err_d           = 1'b1;
          ack_d[grant_q]  = 1'b1;
          state_d         = S_RESP;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_RESP: begin
        last_d  = grant_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= GID_W'(NUM_LANES - 1);
      tik_q   <= '0;
      timer_q <= '0;
      speed_q <= '0;
      err_q   <= 1'b0;
      ack_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      tik_q   <= tik_d;
      timer_q <= timer_d;
      speed_q <= speed_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.dp_start  = start_q;
  assign bus.dp_tik    = tik_q;
  assign bus.ack       = ack_q;
  assign bus.speed_out = speed_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
  assign bus.grant_id  = grant_q;
endmodule

// File: tb/tb_etc_calc_arbiter.sv
// Directed self-checking bench for etc_calc_arbiter: lanes and datapath are
// modelled by the tasks below, sampling and driving on the falling edge.
module tb_etc_calc_arbiter;
  localparam int NL  = 4;
  localparam int WT  = 16;
  localparam int WS  = 14;
  localparam int TMO = 1023;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_start  = 0;

  etc_calc_arbiter_if #(.NUM_LANES(NL), .WIDTH_TIK(WT), .WIDTH_SPEED(WS)) a_if ();

  etc_calc_arbiter #(.NUM_LANES(NL), .WIDTH_TIK(WT), .WIDTH_SPEED(WS), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if.master)
  );

  always #5 clk = ~clk;

  // Count launch pulses away from the active edge
  always @(negedge clk) begin
    if (a_if.dp_start === 1'b1) n_start++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (a_if.dp_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_start_seen"}, 32'(a_if.dp_start), 32'd1);
  endtask

  // Serve one grant: datapath answers k cycles after dp_start.
  task automatic serve(input int k, input logic [WS-1:0] spd, input int lane,
                       input logic [WT-1:0] tik, input string tag);
    logic saw_ack = 1'b0;
    wait_start(tag);
    check_val({tag, "_dp_tik"}, 32'(a_if.dp_tik), 32'(tik));
    for (int c = 1; c <= k; c++) begin
      @(negedge clk);
      if (c == 1) check_val({tag, "_start_pulse"}, 32'(a_if.dp_start), 32'd0);
      if (a_if.ack !== '0) saw_ack = 1'b1;
    end
    check_val({tag, "_no_early_ack"}, 32'(saw_ack), 32'd0);
    a_if.dp_done  = 1'b1;
    a_if.dp_speed = spd;
    @(negedge clk);
    a_if.dp_done  = 1'b0;
    a_if.dp_speed = '0;
    check_val({tag, "_ack"}, 32'(a_if.ack), 32'(1 << lane));
    check_val({tag, "_speed"}, 32'(a_if.speed_out), 32'(spd));
    check_val({tag, "_err"}, 32'(a_if.err), 32'd0);
    check_val({tag, "_gid"}, 32'(a_if.grant_id), 32'(lane));
    a_if.req[lane] = 1'b0;
  endtask

  initial begin
    int s0;
    logic bad;
    reset         = 1'b1;
    a_if.req      = '0;
    a_if.tik_in   = {16'd400, 16'd1200, 16'd200, 16'd100};
    a_if.dp_done  = 1'b0;
    a_if.dp_speed = '0;
    repeat (2) @(negedge clk);
    check_val("rst_ack", 32'(a_if.ack), 32'd0);
    check_val("rst_busy", 32'(a_if.busy), 32'd0);
    check_val("rst_dp_tik", 32'(a_if.dp_tik), 32'd0);
    check_val("rst_gid", 32'(a_if.grant_id), 32'd0);
    check_val("rst_start", 32'(a_if.dp_start), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: single request on lane 2
    a_if.req = 4'b0100;
    serve(3, 14'd88, 2, 16'd1200, "t1");
    @(negedge clk);
    check_val("t1_ack_one_cycle", 32'(a_if.ack), 32'd0);
    check_val("t1_busy_idle", 32'(a_if.busy), 32'd0);

    // 2: all lanes at once, expect 0,1,2,3 (last after t1 is 2 -> restart below)
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    a_if.tik_in = {16'd400, 16'd300, 16'd200, 16'd100};
    s0 = n_start;
    a_if.req = 4'b1111;
    serve(2, 14'd10, 0, 16'd100, "t2_l0");
    serve(2, 14'd20, 1, 16'd200, "t2_l1");
    serve(2, 14'd30, 2, 16'd300, "t2_l2");
    wait_start("t2_l3_pre");
    @(negedge clk);
    check_val("t2_busy_wait", 32'(a_if.busy), 32'd1);
    a_if.dp_done  = 1'b1;
    a_if.dp_speed = 14'd40;
    @(negedge clk);
    a_if.dp_done  = 1'b0;
    check_val("t2_l3_ack", 32'(a_if.ack), 32'd8);
    check_val("t2_l3_speed", 32'(a_if.speed_out), 32'd40);
    a_if.req[3] = 1'b0;
    @(negedge clk);
    check_val("t2_busy_end", 32'(a_if.busy), 32'd0);
    check_val("t2_start_count", 32'(n_start - s0), 32'd4);

    // 3: lanes 1 and 3 pending, lane 1 re-requests -> 1,3,1
    a_if.req = 4'b1010;
    serve(2, 14'd111, 1, 16'd200, "t3_a");
    @(negedge clk);
    a_if.req[1] = 1'b1;
    serve(2, 14'd333, 3, 16'd400, "t3_b");
    serve(2, 14'd112, 1, 16'd200, "t3_c");
    @(negedge clk);

    // 4: timeout on lane 0 (last=1 -> search 2,3,0)
    a_if.req = 4'b0001;
    wait_start("t4");
    bad = 1'b0;
    for (int c = 1; c <= TMO + 1; c++) begin
      @(negedge clk);
      if (a_if.ack !== '0) bad = 1'b1;
    end
    check_val("t4_no_early_ack", 32'(bad), 32'd0);
    @(negedge clk);
    check_val("t4_ack", 32'(a_if.ack), 32'd1);
    check_val("t4_err", 32'(a_if.err), 32'd1);
    check_val("t4_speed_zero", 32'(a_if.speed_out), 32'd0);
    a_if.req = '0;
    @(negedge clk);
    check_val("t4_err_one_cycle", 32'(a_if.err), 32'd0);
    a_if.dp_done  = 1'b1;
    a_if.dp_speed = 14'd99;
    @(negedge clk);
    a_if.dp_done  = 1'b0;
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (a_if.ack !== '0 || a_if.busy !== 1'b0) bad = 1'b1;
    end
    check_val("t4_stray_done", 32'(bad), 32'd0);

    // 5: done arrives exactly when timer==TIMEOUT
    a_if.tik_in = {16'd400, 16'd777, 16'd200, 16'd100};
    a_if.req = 4'b0100;
    serve(TMO + 1, 14'd50, 2, 16'd777, "t5");
    @(negedge clk);

    // 6: reset in WAIT for lane 2, then lane-0-first priority restored
    a_if.req = 4'b0100;
    wait_start("t6");
    repeat (2) @(negedge clk);
    reset    = 1'b1;
    a_if.req = '0;
    #1;
    check_val("t6_rst_busy", 32'(a_if.busy), 32'd0);
    check_val("t6_rst_gid", 32'(a_if.grant_id), 32'd0);
    check_val("t6_rst_dp_tik", 32'(a_if.dp_tik), 32'd0);
    check_val("t6_rst_speed", 32'(a_if.speed_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    a_if.dp_done = 1'b1;
    @(negedge clk);
    a_if.dp_done = 1'b0;
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (a_if.ack !== '0 || a_if.busy !== 1'b0) bad = 1'b1;
    end
    check_val("t6_no_ack_after_abort", 32'(bad), 32'd0);
    a_if.req = 4'b1100;
    serve(2, 14'd61, 2, 16'd777, "t6_l2");
    serve(2, 14'd62, 3, 16'd400, "t6_l3");
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
